// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, drives instr_mem, and buffers
// returned words in a 2-entry FIFO behind a valid/ready handshake.
module instr_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  addr,
  input  logic [INSTR_W-1:0] instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  logic               r_infl;
  logic [ADDR_W-1:0]  r_infl_pc;
  logic [1:0]         r_count;
  logic [ADDR_W-1:0]  r_pc0;
  logic [ADDR_W-1:0]  r_pc1;
  logic [INSTR_W-1:0] r_ins0;
  logic [INSTR_W-1:0] r_ins1;

  logic               w_pop;
  logic               w_push;
  logic [1:0]         w_count_nx;
  logic               w_issue;
  logic               w_slot1;

  assign w_pop      = (r_count != 2'd0) & out_ready;
  assign w_push     = r_infl;
  assign w_count_nx = r_count + {1'b0, w_push} - {1'b0, w_pop};
  // Only fetch when the word can land in the FIFO without overflow.
  assign w_issue    = (w_count_nx <= 2'd1) & ~redirect_valid;
  // After a pop, a lone surviving entry sits in slot 0, so the
  // incoming word goes behind it only when nothing leaves.
  assign w_slot1    = (r_count == 2'd1) & ~w_pop;

  assign out_valid  = (r_count != 2'd0);
  assign out_pc     = r_pc0;
  assign out_instr  = r_ins0;

  // PC, in-flight tracking and occupancy; redirect flushes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= RESET_PC;
      r_infl    <= 1'b0;
      r_infl_pc <= '0;
      r_count   <= 2'd0;
    end else if (redirect_valid) begin
      addr      <= redirect_pc;
      r_infl    <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      r_count <= w_count_nx;
      r_infl  <= w_issue;
      if (w_issue) begin
        r_infl_pc <= addr;
        addr      <= addr + ADDR_W'(1);
      end
    end
  end

  // FIFO storage; slot 0 is the head and keeps its contents when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc0  <= '0;
      r_pc1  <= '0;
      r_ins0 <= '0;
      r_ins1 <= '0;
    end else if (!redirect_valid) begin
      if (w_pop && (r_count == 2'd2)) begin
        r_pc0  <= r_pc1;
        r_ins0 <= r_ins1;
      end
      if (w_push) begin
        if (w_slot1) begin
          r_pc1  <= r_infl_pc;
          r_ins1 <= instr;
        end else begin
          r_pc0  <= r_infl_pc;
          r_ins0 <= instr;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed opening, then random traffic
// checked each cycle against a queue-based reference model.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic        rst_w;
  logic [31:0] addr_w;
  logic [31:0] instr_w;
  logic        ov_w;
  logic [31:0] oi_w;
  logic [31:0] op_w;

  int checks;
  int errors;
  int cyc;

  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  bit          m_inf;
  logic [31:0] m_inf_pc;
  logic [31:0] m_last_pc;
  logic [31:0] m_last_ins;

  instr_fetch #(
    .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)
  ) u_dut (
    .clk(clk), .rst(rst), .addr(addr), .instr(instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  instr_fetch #(
    .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFE)
  ) u_wrap (
    .clk(clk), .rst(rst_w), .addr(addr_w), .instr(instr_w),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(ov_w), .out_ready(1'b1),
    .out_instr(oi_w), .out_pc(op_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  // Memory with one-cycle read latency.
  always @(posedge clk) begin
    instr   <= memf(addr);
    instr_w <= memf(addr_w);
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Advance the reference model by one clock edge with the given inputs.
  function automatic void model_step(bit r, bit rv, logic [31:0] rp, bit rdy);
    if (r) begin
      m_pc = 32'h0;
      m_q.delete();
      m_inf = 1'b0;
      m_last_pc = 32'h0;
      m_last_ins = 32'h0;
    end else if (rv) begin
      m_q.delete();
      m_inf = 1'b0;
      m_pc = rp;
    end else begin
      if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
      if (m_inf) m_q.push_back(m_inf_pc);
      if (m_q.size() <= 1) begin
        m_inf = 1'b1;
        m_inf_pc = m_pc;
        m_pc = m_pc + 32'd1;
      end else begin
        m_inf = 1'b0;
      end
    end
  endfunction

  task automatic compare_model();
    chk("out_valid", {31'h0, out_valid}, {31'h0, m_q.size() != 0});
    chk("addr", addr, m_pc);
    if (m_q.size() != 0) begin
      chk("out_pc", out_pc, m_q[0]);
      chk("out_instr", out_instr, memf(m_q[0]));
      m_last_pc = m_q[0];
      m_last_ins = memf(m_q[0]);
    end else begin
      chk("hold_pc", out_pc, m_last_pc);
      chk("hold_instr", out_instr, m_last_ins);
    end
  endtask

  task automatic literal_checks();
    logic [31:0] wexp[4];
    wexp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    if (cyc == -1) begin
      chk("rst_addr", addr, 32'h0);
      chk("rst_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_instr", out_instr, 32'h0);
      chk("rst_wrap_addr", addr_w, 32'hFFFF_FFFE);
    end
    if (cyc >= 2 && cyc <= 4) begin
      chk("start_valid", {31'h0, out_valid}, 32'h1);
      chk("start_pc", out_pc, 32'(cyc - 2));
      chk("start_instr", out_instr, 32'hA000_0000 + 32'(cyc - 2));
    end
    if (cyc == 8) begin
      chk("stall_addr", addr, 32'd4);
      chk("stall_pc", out_pc, 32'd2);
    end
    if (cyc >= 9 && cyc <= 12) begin
      chk("resume_valid", {31'h0, out_valid}, 32'h1);
      chk("resume_pc", out_pc, 32'(cyc - 7));
    end
    if (cyc == 13) chk("redir_pop_pc", out_pc, 32'd6);
    if (cyc == 14) begin
      chk("redir_valid", {31'h0, out_valid}, 32'h0);
      chk("redir_addr", addr, 32'd20);
    end
    if (cyc == 16) begin
      chk("redir_out_pc", out_pc, 32'd20);
      chk("redir_out_instr", out_instr, 32'hA000_0014);
    end
    if (cyc >= 2 && cyc <= 5) begin
      chk("wrap_valid", {31'h0, ov_w}, 32'h1);
      chk("wrap_pc", op_w, wexp[cyc-2]);
    end
    if (cyc == 2) chk("wrap_addr", addr_w, 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rst_w = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b1;
    for (int n = 0; n < 3400; n++) begin
      @(negedge clk);
      cyc = n - 2;
      if (n > 0) begin
        compare_model();
        literal_checks();
      end
      if (cyc <= 40) begin
        rst = (cyc < 0);
        out_ready = !(cyc >= 4 && cyc <= 8);
        redirect_valid = (cyc == 13);
        redirect_pc = 32'd20;
      end else begin
        rst = ($urandom_range(0, 49) == 0);
        out_ready = ($urandom_range(0, 9) < 6);
        redirect_valid = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 3) == 0)
          redirect_pc = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        else
          redirect_pc = 32'($urandom_range(0, 40));
      end
      rst_w = (cyc < 0);
      model_step(rst, redirect_valid, redirect_pc, out_ready);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
